// File: rtl/bus_memory.sv
// DATA_W x DEPTH bus RAM with address register, async read and a handshaked bulk loader (one word/clk while load_valid, CPU held off via load_busy).
// Optional MEM_AUTOINC_EN: IDLE read/write strobes post-increment the address register modulo DEPTH.
module bus_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus,
  input  logic              en_write_mem_adr,
  input  logic              en_write_mem,
  input  logic              en_read_mem,
  output logic [DATA_W-1:0] last_read,
  input  logic              load_start,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] adr_q;
  logic [ADDR_W-1:0] load_ptr_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              adr_in_range;
  logic              cpu_we;
  logic              ld_acc;
  logic              we;
  logic [ADDR_W-1:0] wr_adr;
  logic [DATA_W-1:0] wr_dat;

  assign adr_in_range = ({1'b0, adr_q} < DEPTH_V);
  assign last_read    = adr_in_range ? mem[adr_q] : '0;

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) state_d = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        load_busy  = 1'b1;
        if (load_valid && (load_last || load_ptr_q == LAST_A)) state_d = DONE;
      end
      DONE: begin
        load_busy = 1'b1;
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_acc = load_ready && load_valid;
  assign cpu_we = (state_q == IDLE) && !en_write_mem_adr && en_write_mem && adr_in_range;
  assign we     = ld_acc || cpu_we;
  assign wr_adr = (state_q == LOAD) ? load_ptr_q : adr_q;
  assign wr_dat = (state_q == LOAD) ? load_data : bus;

`ifdef MEM_AUTOINC_EN
  logic [ADDR_W-1:0] adr_inc;
  assign adr_inc = (adr_q >= LAST_A) ? '0 : adr_q + 1'b1;
`else
  logic unused_rd;
  assign unused_rd = en_read_mem;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      load_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (en_write_mem_adr) adr_q <= bus[ADDR_W-1:0];
`ifdef MEM_AUTOINC_EN
          else if (en_write_mem || en_read_mem) adr_q <= adr_inc;
`endif
          if (load_start) load_ptr_q <= '0;
        end
        LOAD: begin
          if (load_valid) load_ptr_q <= load_ptr_q + 1'b1;
        end
        DONE: adr_q <= '0;
        default: ;
      endcase
    end
  end

  // Contents survive reset; only suppress writes while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && we) mem[wr_adr] <= wr_dat;
  end

endmodule

// File: tb/tb_bus_memory.sv
module tb_bus_memory;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus;
  logic       en_write_mem_adr, en_write_mem, en_read_mem;
  logic [7:0] last_read;
  logic       load_start;
  logic [7:0] load_data;
  logic       load_valid, load_last;
  logic       load_ready, load_busy, load_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_memory dut (
    .clk(clk), .reset(reset), .bus(bus),
    .en_write_mem_adr(en_write_mem_adr), .en_write_mem(en_write_mem),
    .en_read_mem(en_read_mem), .last_read(last_read),
    .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
    .load_last(load_last), .load_ready(load_ready), .load_busy(load_busy),
    .load_done(load_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [7:0] a);
    bus = a;
    en_write_mem_adr = 1'b1;
    tick();
    en_write_mem_adr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus = 8'h00; en_write_mem_adr = 0; en_write_mem = 0; en_read_mem = 0;
    load_start = 0; load_data = 8'h00; load_valid = 0; load_last = 0;
    #1;
    checks++;
    if ({load_ready, load_busy, load_done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000", {load_ready, load_busy, load_done});
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({load_ready, load_busy, load_done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_flags got=%b want=000", {load_ready, load_busy, load_done});
    end
  endtask

  task automatic test_full_load;
    int ready_cnt = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (load_ready === 1'b1 && load_busy === 1'b1 && load_done === 1'b0) ready_cnt++;
      load_data  = 8'h10 + 8'(i);
      load_valid = 1'b1;
      tick();
    end
    load_valid = 1'b0;
    checks++;
    if (ready_cnt != 16) begin
      failures++;
      $display("FAIL full_ready_cycles got=%0d want=16", ready_cnt);
    end
    checks++;
    if ({load_ready, load_busy, load_done} !== 3'b011) begin
      failures++;
      $display("FAIL full_done_state got=%b want=011", {load_ready, load_busy, load_done});
    end
    tick();
    checks++;
    if ({load_ready, load_busy, load_done} !== 3'b000) begin
      failures++;
      $display("FAIL full_after_done got=%b want=000", {load_ready, load_busy, load_done});
    end
    checks++;
    if (last_read !== 8'h10) begin
      failures++;
      $display("FAIL full_addr0 got=%h want=10", last_read);
    end
    for (int i = 0; i < 16; i++) begin
      set_addr(8'(i));
      checks++;
      if (last_read !== 8'h10 + 8'(i)) begin
        failures++;
        $display("FAIL full_data[%0d] got=%h want=%h", i, last_read, 8'h10 + 8'(i));
      end
    end
  endtask

  task automatic test_partial_load;
    logic [7:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b0;
      tick();
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = (i == 2);
      tick();
      if (i == 1) begin
        checks++;
        if ({load_ready, load_done} !== 2'b10) begin
          failures++;
          $display("FAIL partial_mid got=%b want=10", {load_ready, load_done});
        end
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks++;
    if (load_done !== 1'b1 || load_ready !== 1'b0) begin
      failures++;
      $display("FAIL partial_done got=%b%b want=10", load_done, load_ready);
    end
    tick();
    checks++;
    if (last_read !== 8'h11) begin
      failures++;
      $display("FAIL partial_d0 got=%h want=11", last_read);
    end
    set_addr(8'h02);
    checks++;
    if (last_read !== 8'h33) begin
      failures++;
      $display("FAIL partial_d2 got=%h want=33", last_read);
    end
    set_addr(8'h03);
    checks++;
    if (last_read !== 8'h13) begin
      failures++;
      $display("FAIL partial_d3_kept got=%h want=13", last_read);
    end
  endtask

  task automatic test_write_read;
    set_addr(8'h05);
    bus = 8'hA7;
    en_write_mem = 1'b1;
    tick();
    en_write_mem = 1'b0;
    bus = 8'h00;
    checks++;
    if (last_read !== 8'hA7) begin
      failures++;
      $display("FAIL write_visible got=%h want=a7", last_read);
    end
    tick();
    checks++;
    if (last_read !== 8'hA7) begin
      failures++;
      $display("FAIL write_hold got=%h want=a7", last_read);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (last_read !== 8'h11) begin
      failures++;
      $display("FAIL reset_addr got=%h want=11", last_read);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous;
    bus = 8'h03;
    en_write_mem_adr = 1'b1;
    en_write_mem = 1'b1;
    tick();
    en_write_mem_adr = 1'b0;
    en_write_mem = 1'b0;
    checks++;
    if (last_read !== 8'h13) begin
      failures++;
      $display("FAIL simul_addr got=%h want=13", last_read);
    end
    set_addr(8'h00);
    checks++;
    if (last_read !== 8'h11) begin
      failures++;
      $display("FAIL simul_no_write got=%h want=11", last_read);
    end
  endtask

  task automatic test_load_abort;
    set_addr(8'h05);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    bus = 8'hFF;
    en_write_mem = 1'b1;
    en_read_mem = 1'b1;
    load_valid = 1'b1;
    load_data = 8'hC0;
    tick();
    load_data = 8'hC1;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({load_busy, load_ready} !== 2'b00) begin
      failures++;
      $display("FAIL abort_busy got=%b want=00", {load_busy, load_ready});
    end
    load_valid = 1'b0;
    en_write_mem = 1'b0;
    en_read_mem = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (last_read !== 8'hC0) begin
      failures++;
      $display("FAIL abort_d0 got=%h want=c0", last_read);
    end
    set_addr(8'h01);
    checks++;
    if (last_read !== 8'hC1) begin
      failures++;
      $display("FAIL abort_d1 got=%h want=c1", last_read);
    end
    set_addr(8'h02);
    checks++;
    if (last_read !== 8'h33) begin
      failures++;
      $display("FAIL abort_d2 got=%h want=33", last_read);
    end
    set_addr(8'h05);
    checks++;
    if (last_read !== 8'hA7) begin
      failures++;
      $display("FAIL load_cpu_blocked got=%h want=a7", last_read);
    end
  endtask

  task automatic test_autoinc;
    set_addr(8'h0F);
    bus = 8'h5A;
    en_write_mem = 1'b1;
    tick();
    en_write_mem = 1'b0;
`ifdef MEM_AUTOINC_EN
    checks++;
    if (last_read !== 8'hC0) begin
      failures++;
      $display("FAIL autoinc_wrap got=%h want=c0", last_read);
    end
    en_read_mem = 1'b1;
    tick();
    en_read_mem = 1'b0;
    checks++;
    if (last_read !== 8'hC1) begin
      failures++;
      $display("FAIL autoinc_read got=%h want=c1", last_read);
    end
    set_addr(8'h0F);
    checks++;
    if (last_read !== 8'h5A) begin
      failures++;
      $display("FAIL autoinc_d15 got=%h want=5a", last_read);
    end
`else
    checks++;
    if (last_read !== 8'h5A) begin
      failures++;
      $display("FAIL noinc_write got=%h want=5a", last_read);
    end
    en_read_mem = 1'b1;
    tick();
    en_read_mem = 1'b0;
    checks++;
    if (last_read !== 8'h5A) begin
      failures++;
      $display("FAIL noinc_read got=%h want=5a", last_read);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_partial_load();
    test_write_read();
    test_simultaneous();
    test_load_abort();
    test_autoinc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
